// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M multiply/divide execution unit.
// Multiply takes two cycles; divide is a 32-step restoring divider.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [1:0]      is_muldiv_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [5:0] LAST_STEP = 6'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [5:0]      cnt_q;
  logic [1:0]      f3_q;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] rem_q;
  logic            qneg_q;
  logic            rneg_q;

  logic            mul_req;
  logic            div_req;
  logic            accept;
  logic            div_sgn;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] spec_res;

  logic                   a_sx;
  logic                   b_sx;
  logic signed [XLEN:0]   mul_a;
  logic signed [XLEN:0]   mul_b;
  logic signed [2*XLEN+1:0] prod;
  logic [XLEN-1:0]        mul_res;

  logic [XLEN:0]   trial;
  logic            q_bit;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;
  logic [XLEN-1:0] quo_fin;
  logic [XLEN-1:0] rem_fin;
  logic [XLEN-1:0] div_res;

  logic unused_ok;

  assign ready_o = (state == S_IDLE);
  assign busy_o  = (state != S_IDLE);

  assign mul_req = (is_muldiv_i == 2'b01);
  assign div_req = (is_muldiv_i == 2'b10);
  assign accept  = valid_i & ready_o & ~flush_i
                 & (mul_req | div_req);

  // Divide operand preparation and special-case detection
  assign div_sgn  = ~funct3_i[0];
  assign a_neg    = div_sgn & rs1_i[XLEN-1];
  assign b_neg    = div_sgn & rs2_i[XLEN-1];
  assign a_abs    = a_neg ? (~rs1_i + 1'b1) : rs1_i;
  assign b_abs    = b_neg ? (~rs2_i + 1'b1) : rs2_i;
  assign div_zero = (rs2_i == '0);
  assign div_ovf  = div_sgn & (rs1_i == INT_MIN)
                  & (rs2_i == '1);

  // Zero divisor wins over overflow; rem flag is funct3[1]
  always_comb begin
    spec_res = '0;
    if (div_zero)
      spec_res = funct3_i[1] ? rs1_i : '1;
    else
      spec_res = funct3_i[1] ? '0 : INT_MIN;
  end

  // 33x33 signed product covers all four multiply flavours
  assign a_sx  = (f3_q == 2'b01) | (f3_q == 2'b10);
  assign b_sx  = (f3_q == 2'b01);
  assign mul_a = $signed({a_sx & op_a[XLEN-1], op_a});
  assign mul_b = $signed({b_sx & op_b[XLEN-1], op_b});
  assign prod  = mul_a * mul_b;

  // Low word for MUL, high word otherwise
  always_comb begin
    mul_res = prod[2*XLEN-1:XLEN];
    if (f3_q == 2'b00)
      mul_res = prod[XLEN-1:0];
  end

  // One restoring step: op_a shifts dividend out, quotient in
  always_comb begin
    trial   = {rem_q, op_a[XLEN-1]} - {1'b0, op_b};
    q_bit   = ~trial[XLEN];
    rem_nxt = {rem_q[XLEN-2:0], op_a[XLEN-1]};
    if (q_bit)
      rem_nxt = trial[XLEN-1:0];
    quo_nxt = {op_a[XLEN-2:0], q_bit};
  end

  // Sign fix-up applied to the final step's outputs
  always_comb begin
    quo_fin = qneg_q ? (~quo_nxt + 1'b1) : quo_nxt;
    rem_fin = rneg_q ? (~rem_nxt + 1'b1) : rem_nxt;
    div_res = f3_q[1] ? rem_fin : quo_fin;
  end

  // Control FSM, step counter and result/valid registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      cnt_q    <= '0;
      valid_o  <= 1'b0;
      result_o <= '0;
    end else begin
      valid_o <= 1'b0;
      if (flush_i) begin
        state <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (accept) begin
              if (mul_req) begin
                state <= S_MUL;
              end else if (div_zero | div_ovf) begin
                state    <= S_DONE;
                valid_o  <= 1'b1;
                result_o <= spec_res;
              end else begin
                state <= S_DIV;
                cnt_q <= '0;
              end
            end
          end
          S_MUL: begin
            state    <= S_DONE;
            valid_o  <= 1'b1;
            result_o <= mul_res;
          end
          S_DIV: begin
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == LAST_STEP) begin
              state    <= S_DONE;
              valid_o  <= 1'b1;
              result_o <= div_res;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Operand capture on accept, divider shift while dividing
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      f3_q   <= '0;
      op_a   <= '0;
      op_b   <= '0;
      rem_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (accept) begin
      f3_q <= funct3_i[1:0];
      if (mul_req) begin
        op_a <= rs1_i;
        op_b <= rs2_i;
      end else begin
        op_a   <= a_abs;
        op_b   <= b_abs;
        rem_q  <= '0;
        qneg_q <= a_neg ^ b_neg;
        rneg_q <= a_neg;
      end
    end else if (state == S_DIV) begin
      op_a  <= quo_nxt;
      rem_q <= rem_nxt;
    end
  end

  // funct3[2] is implied by the class; top product bits never used
  assign unused_ok = ^{funct3_i[2], prod[2*XLEN+1:2*XLEN]};

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit
// results, latencies, flush, reset and ignored requests.
module tb_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [1:0]  is_muldiv_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        flush_i;
  logic        ready_o;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .is_muldiv_i (is_muldiv_i),
    .funct3_i    (funct3_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .flush_i     (flush_i),
    .ready_o     (ready_o),
    .busy_o      (busy_o),
    .valid_o     (valid_o),
    .result_o    (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] cls,
                       input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] b);
    valid_i     = 1'b1;
    is_muldiv_i = cls;
    funct3_i    = f3;
    rs1_i       = a;
    rs2_i       = b;
  endtask

  task automatic run_op(input string tag,
                        input logic [1:0] cls,
                        input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int lat,
                        input logic [31:0] exp);
    int cyc;
    bit seen;
    @(negedge clk_i);
    check({tag, "_rdy"}, 32'(ready_o), 32'd1);
    drive(cls, f3, a, b);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge clk_i);
      valid_i = 1'b0;
      cyc++;
      if (valid_o) seen = 1'b1;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(lat));
    check({tag, "_res"}, result_o, exp);
    check({tag, "_bsy"}, 32'(busy_o), 32'd1);
    @(negedge clk_i);
    check({tag, "_vpulse"}, 32'(valid_o), 32'd0);
    check({tag, "_rdy2"}, 32'(ready_o), 32'd1);
  endtask

  initial begin
    logic [31:0] prev;
    int vcnt;

    rst_i       = 1'b1;
    valid_i     = 1'b0;
    is_muldiv_i = 2'b00;
    funct3_i    = 3'b000;
    rs1_i       = '0;
    rs2_i       = '0;
    flush_i     = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_rdy", 32'(ready_o), 32'd1);
    check("rst_bsy", 32'(busy_o), 32'd0);
    check("rst_vld", 32'(valid_o), 32'd0);
    check("rst_res", result_o, 32'd0);
    rst_i = 1'b0;

    run_op("mul",    2'b01, 3'b000, 32'd7, 32'hFFFF_FFFD,
           2, 32'hFFFF_FFEB);
    run_op("mulh",   2'b01, 3'b001, 32'h8000_0000, 32'h8000_0000,
           2, 32'h4000_0000);
    run_op("mulhu",  2'b01, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           2, 32'hFFFF_FFFE);
    run_op("mulhsu", 2'b01, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           2, 32'hFFFF_FFFF);
    run_op("mulh2",  2'b01, 3'b001, 32'hFFFF_FFFF, 32'h0000_0002,
           2, 32'hFFFF_FFFF);

    run_op("div",    2'b10, 3'b100, 32'hFFFF_FFF9, 32'd2,
           33, 32'hFFFF_FFFD);
    run_op("rem",    2'b10, 3'b110, 32'hFFFF_FFF9, 32'd2,
           33, 32'hFFFF_FFFF);
    run_op("divu",   2'b10, 3'b101, 32'd100, 32'd7, 33, 32'd14);
    run_op("remu",   2'b10, 3'b111, 32'd100, 32'd7, 33, 32'd2);
    run_op("div_pn", 2'b10, 3'b100, 32'd100, 32'hFFFF_FFF9,
           33, 32'hFFFF_FFF2);
    run_op("rem_pn", 2'b10, 3'b110, 32'd100, 32'hFFFF_FFF9,
           33, 32'd2);
    run_op("rem_np", 2'b10, 3'b110, 32'hFFFF_FF9C, 32'd7,
           33, 32'hFFFF_FFFE);
    run_op("divu_b", 2'b10, 3'b101, 32'hFFFF_FFFF, 32'd1,
           33, 32'hFFFF_FFFF);

    run_op("div0",   2'b10, 3'b100, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
    run_op("rem0",   2'b10, 3'b110, 32'd5, 32'd0, 1, 32'd5);
    run_op("divu0",  2'b10, 3'b101, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
    run_op("dovf",   2'b10, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF,
           1, 32'h8000_0000);
    run_op("rovf",   2'b10, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF,
           1, 32'd0);

    // flush at T+10 of a divide
    @(negedge clk_i);
    prev = result_o;
    drive(2'b10, 3'b101, 32'd100, 32'd7);
    vcnt = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_i);
      valid_i = 1'b0;
      if (valid_o) vcnt++;
    end
    check("fl_bsy", 32'(busy_o), 32'd1);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    if (valid_o) vcnt++;
    check("fl_rdy", 32'(ready_o), 32'd1);
    check("fl_bsy2", 32'(busy_o), 32'd0);
    check("fl_res", result_o, prev);
    repeat (40) begin
      @(negedge clk_i);
      if (valid_o) vcnt++;
    end
    check("fl_novld", 32'(vcnt), 32'd0);
    run_op("fl_mul", 2'b01, 3'b000, 32'd3, 32'd4, 2, 32'd12);

    // flush together with a request
    @(negedge clk_i);
    drive(2'b01, 3'b000, 32'd9, 32'd9);
    flush_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    flush_i = 1'b0;
    check("flv_bsy", 32'(busy_o), 32'd0);
    check("flv_rdy", 32'(ready_o), 32'd1);

    // reset in the middle of a divide
    @(negedge clk_i);
    drive(2'b10, 3'b100, 32'd100, 32'd7);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_i);
      valid_i = 1'b0;
    end
    check("mr_bsy", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("mr_rdy", 32'(ready_o), 32'd1);
    check("mr_bsy2", 32'(busy_o), 32'd0);
    check("mr_vld", 32'(valid_o), 32'd0);
    check("mr_res", result_o, 32'd0);
    vcnt = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (valid_o) vcnt++;
    end
    check("mr_novld", 32'(vcnt), 32'd0);

    // requests with class 00 and 11 are ignored
    @(negedge clk_i);
    drive(2'b00, 3'b000, 32'd2, 32'd3);
    @(negedge clk_i);
    valid_i = 1'b0;
    check("ig00_bsy", 32'(busy_o), 32'd0);
    drive(2'b11, 3'b100, 32'd2, 32'd3);
    @(negedge clk_i);
    valid_i = 1'b0;
    check("ig11_bsy", 32'(busy_o), 32'd0);
    check("ig_rdy", 32'(ready_o), 32'd1);
    check("ig_vld", 32'(valid_o), 32'd0);

    run_op("last", 2'b01, 3'b000, 32'd6, 32'd7, 2, 32'd42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle RV32M multiply/divide execution unit in the EX stage, directly downstream of the decode control unit. It accepts operations flagged by the decoder's `is_muldiv` class (01 = multiply, 10 = divide/remainder), together with funct3 and both register operands. It produces a 32-bit result with a one-cycle valid pulse. While an operation is in flight it asserts `busy_o` so the pipeline can stall.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; one clock, synchronous, active-high.
- `valid_i`  in  1  request strobe from EX.
- `is_muldiv_i`  in  2  operation class: 01 = mul, 10 = div/rem; 00 and 11 are not requests.
- `funct3_i`  in  3  RV32M funct3 selecting the exact operation.
- `rs1_i`  in  32  operand A (multiplicand / dividend).
- `rs2_i`  in  32  operand B (multiplier / divisor).
- `flush_i`  in  1  abort any in-flight operation; pipeline flush.
- `ready_o`  out  1  unit idle and able to accept this cycle.
- `busy_o`  out  1  operation in flight; pipeline stall request.
- `valid_o`  out  1  one-cycle pulse: `result_o` holds a new result.
- `result_o`  out  32  result; holds its value until the next completion.

## Operation
- **States:** IDLE, MUL, DIV, DONE.
- **Combinational outputs:** `ready_o` = (state==IDLE); `busy_o` = (state!=IDLE).
- **Accept:** `valid_i & ready_o & ~flush_i & is_muldiv_i∈{01,10}`.
  - The unit registers operands, funct3 and class on acceptance.
  - Requests with class 00/11 are ignored and the unit stays in IDLE.
- **Multiply (class 01):**
  - funct3[1:0]: 00 MUL (low 32), 01 MULH (s×s high), 10 MULHSU (rs1 signed × rs2 unsigned, high), 11 MULHU (u×u high).
  - Implementation: sign/zero-extend both operands to 33 bits, form the 66-bit product, and select bits [31:0] or [63:32].
  - The product is registered in state MUL.
  - Transitions: IDLE → MUL → DONE.
- **Divide (class 10):**
  - funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
  - Signed ops take absolute values of both operands.
  - The core is a restoring radix-2 divider with a 6-bit iteration counter, one quotient bit per cycle, 32 iterations.
  - Sign fix-up in DONE:
    - Quotient is negated if the operand signs differ (signed ops only).
    - Remainder takes the sign of the dividend.
  - Transitions: IDLE → DIV (32 cycles) → DONE.
- **Divide special cases:** these bypass DIV and go IDLE → DONE.
  - Divisor == 0: quotient = 0xFFFFFFFF (signed and unsigned); remainder = rs1.
  - Signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF, DIV/REM only): quotient = 0x80000000; remainder = 0.
- **DONE:** lasts exactly one cycle; `valid_o` = 1 and `result_o` is loaded; next state is IDLE.
- **Flush:** `flush_i` in any state forces IDLE at the next edge.
  - No `valid_o` is produced for the aborted operation.
  - `result_o` keeps its previous value.
  - When `flush_i` and `valid_i` are asserted in the same cycle, the request is not accepted.
- **Reset:** state = IDLE, `valid_o` = 0, `result_o` = 0, counter = 0, `ready_o` = 1, `busy_o` = 0.
  - This applies regardless of the state at the time of reset, including mid-divide.

## Timing
- Cycle T is the acceptance cycle.
- MUL*: `valid_o` is high in cycle T+2; `ready_o` returns high in cycle T+3.
- Normal DIV/REM:
  - 32 DIV cycles occupy T+1 … T+32.
  - `valid_o` is high in cycle T+33; `ready_o` returns high in cycle T+34.
- Special-case DIV/REM: `valid_o` is high in cycle T+1; `ready_o` returns high in cycle T+2.
- `busy_o` is high from T+1 through the DONE cycle inclusive.
- No back-to-back acceptance: no request can be accepted during the DONE cycle.
- `valid_o` is never high for more than one cycle per operation.

## Test plan
- **MUL (funct3 000):** rs1 = 7, rs2 = 0xFFFFFFFD → `result_o` = 0xFFFFFFEB, `valid_o` in T+2 only, `ready_o` in T+3.
- **Multiply-high variants:**
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- **Divide/remainder:**
  - DIV −7/2 → 0xFFFFFFFD and REM −7/2 → 0xFFFFFFFF, with `valid_o` at T+33.
  - DIVU 100/7 → 14 and REMU 100/7 → 2.
- **Special cases:**
  - DIV 5/0 → 0xFFFFFFFF at T+1; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- **Flush:** `flush_i` at T+10 of a DIV → no `valid_o`, `result_o` unchanged, `ready_o` high at T+11; a following MUL 3×4 → 12 at its own T+2.
- **Reset and ignored request:**
  - `rst_i` pulsed at T+5 of a DIV → next cycle `ready_o` = 1, `busy_o` = 0, `valid_o` = 0, `result_o` = 0.
  - `valid_i` with class 00 → no acceptance, `busy_o` stays 0.
